nes_palette_ram: RTL and testbench
==================================

# nes_palette_ram

Writable NES palette memory replacing the fixed palette ROMs. It holds 2^ADDR_W colour indices and self-loads a default palette after reset or on request. It serves a free-running renderer read port and a CPU read/write port with PPU $3F10/$14/$18/$1C mirroring. It sits between the PPU register block (CPU side) and the pixel pipeline (render side).

## Interface
- ADDR_W, 5: palette address width; depth = 2^ADDR_W.
- DATA_W, 6: stored colour index width; init values are truncated to DATA_W LSBs.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init_req  in  1  one-cycle pulse; reloads the default palette.
- ren_addr  in  ADDR_W  renderer read address, sampled every cycle.
- ren_data  out  DATA_W  renderer read data.
- cpu_addr  in  ADDR_W  CPU read/write address.
- cpu_wr_valid  in  1  CPU write request.
- cpu_wr_ready  out  1  write accepted when high together with cpu_wr_valid.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rd_en  in  1  CPU read request.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_rvalid  out  1  cpu_rdata valid pulse.
- gray  in  1  grayscale enable; present only with NES_PALETTE_GRAY_EN.

## Operation
- Mirroring applies to every access, including init: if addr[1:0]==0, addr[ADDR_W-1] is cleared before indexing. This is only meaningful for ADDR_W≥5.
- FSM states:
  - INIT: counter idx writes PAL_INIT[idx] into entry idx, one entry per cycle, idx 0..2^ADDR_W-1, then goes to RUN.
  - RUN: normal operation; init_req in RUN goes to INIT with idx=0.
- Reset forces INIT with idx=0. rst_n asserted mid-init restarts the load from 0.
- cpu_wr_ready = (state==RUN), registered. A write is performed when cpu_wr_valid && cpu_wr_ready.
- A write accepted in the same cycle as init_req is performed. The init sequence then overwrites it.
- CPU read is accepted only in RUN; in INIT cpu_rd_en is ignored and cpu_rvalid stays 0.
- CPU read and write in the same cycle: the write is performed and the read returns the new data (write-through).
- Renderer read in the same cycle as a CPU write to the same mirrored entry returns the old data (read-before-write).
- Renderer reads during INIT return 0.

## Timing
- Reset values: ren_data=0, cpu_rdata=0, cpu_rvalid=0, cpu_wr_ready=0, state=INIT, idx=0.
- Init takes exactly 2^ADDR_W cycles after rst_n deasserts. cpu_wr_ready rises on the edge that writes the last entry (edge 32 for the default ADDR_W).
- Read latency: 1 cycle on both ports. cpu_rvalid is a one-cycle pulse aligned with cpu_rdata.
- A written value is visible to reads issued on the following cycle.
- The idx counter stops at 2^ADDR_W-1; there is no wrap into a second pass.

## Configuration
- NES_PALETTE_GRAY_EN defined: gray port exists. When gray=1, both ren_data and cpu_rdata are ANDed with mask {2'b11, 0…} (only bits [5:4] kept), registered with the data so latency is unchanged.
- Not defined: no gray port; data is passed unmasked.

## Structure
- Package nes_palette_pkg holds:
  - PAL_INIT: 32 × 8-bit default table, in order: 15 2D 27 30 15 30 1A 09 15 2D 27 30 15 27 17 0F 15 1C 15 14 15 21 15 30 15 1C 15 14 15 02 38 3C (hex). For ADDR_W>5 the table repeats modulo 32.
  - The state enum {INIT, RUN}.
  - The mirror_addr function.
  - GRAY_MASK.
- One sub-module, nes_palette_init_fsm: state, idx counter, init write strobe/address/data, cpu_wr_ready.
- The storage array and read registers stay in the top level.

## Test plan
- Reset release, wait 32 cycles, then ren_addr=0x1D → ren_data=0x02 next cycle; ren_addr=0x1F → 0x3C.
- CPU write 0x10←0x2A → CPU read 0x00 gives 0x2A with cpu_rvalid; ren_addr=0x10 gives 0x2A.
- rst_n pulsed low at init cycle 10 → cpu_wr_ready low, rises 32 cycles after release; entry 0x05 reads 0x30.
- In RUN, write 0x03←0x11 simultaneously with init_req → cpu_wr_ready low for 32 cycles; entry 0x03 then reads 0x30.
- Same-cycle renderer read of 0x07 and CPU write 0x07←0x3F → ren_data=0x09; next renderer read gives 0x3F.
- With NES_PALETTE_GRAY_EN and gray=1, read 0x02 (0x27) → 0x20; gray=0 → 0x27.

Source files
------------

// File: rtl/nes_palette_pkg.sv
// Shared types, default palette table and address helpers for the NES palette RAM.
package nes_palette_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } pal_state_t;

    // Grayscale keeps only the luma bits [5:4] of the colour index.
    localparam logic [7:0] GRAY_MASK = 8'h30;

    localparam logic [7:0] PAL_INIT [32] = '{
        8'h15, 8'h2D, 8'h27, 8'h30, 8'h15, 8'h30, 8'h1A, 8'h09,
        8'h15, 8'h2D, 8'h27, 8'h30, 8'h15, 8'h27, 8'h17, 8'h0F,
        8'h15, 8'h1C, 8'h15, 8'h14, 8'h15, 8'h21, 8'h15, 8'h30,
        8'h15, 8'h1C, 8'h15, 8'h14, 8'h15, 8'h02, 8'h38, 8'h3C
    };

    function automatic logic [7:0] pal_init_value(input logic [4:0] idx);
        return PAL_INIT[idx];
    endfunction

    // Sprite backdrop entries ($3F10/14/18/1C) alias the background ones.
    function automatic logic [15:0] mirror_addr(input logic [15:0] addr, input int unsigned addr_w);
        logic [15:0] m;
        m = addr;
        if (addr_w >= 5 && addr[1:0] == 2'b00)
            m = addr & ~(16'h0001 << (addr_w - 1));
        return m;
    endfunction

endpackage

// File: rtl/nes_palette_ram_if.sv
// CPU-side read/write bus of the palette RAM (PPU register block to palette).
interface nes_palette_ram_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 6
);
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_wr_valid;
    logic              cpu_wr_ready;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rd_en;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    modport master (
        output cpu_addr, cpu_wr_valid, cpu_wdata, cpu_rd_en,
        input  cpu_wr_ready, cpu_rdata, cpu_rvalid
    );

    modport slave (
        input  cpu_addr, cpu_wr_valid, cpu_wdata, cpu_rd_en,
        output cpu_wr_ready, cpu_rdata, cpu_rvalid
    );
endinterface

// File: rtl/nes_palette_init_fsm.sv
// Init/run sequencer: walks every palette entry once loading the default table.
module nes_palette_init_fsm
    import nes_palette_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req,
    output logic              run,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data,
    output logic              cpu_wr_ready
);
    pal_state_t        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            idx_q        <= '0;
            cpu_wr_ready <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cpu_wr_ready <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        init_we   = 1'b0;
        run       = 1'b0;
        init_addr = idx_q;
        init_data = DATA_W'(pal_init_value(5'(idx_q)));
        case (state_q)
            INIT: begin
                init_we = 1'b1;
                // idx parks on the last entry; no second pass.
                if (idx_q == '1)
                    state_d = RUN;
                else
                    idx_d = idx_q + 1'b1;
            end
            RUN: begin
                run = 1'b1;
                if (init_req) begin
                    state_d = INIT;
                    idx_d   = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

endmodule

// File: rtl/nes_palette_ram.sv
// Writable NES palette RAM with renderer and CPU ports and backdrop mirroring.
// Optional grayscale output masking is enabled by defining NES_PALETTE_GRAY_EN.
module nes_palette_ram
    import nes_palette_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req,
    input  logic [ADDR_W-1:0] ren_addr,
    output logic [DATA_W-1:0] ren_data,
`ifdef NES_PALETTE_GRAY_EN
    input  logic              gray,
`endif
    nes_palette_ram_if.slave  cpu
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] GRAY_BITS = DATA_W'(GRAY_MASK);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              init_we;
    logic              wr_ready;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;
    logic [ADDR_W-1:0] init_phys;
    logic [ADDR_W-1:0] ren_phys;
    logic [ADDR_W-1:0] cpu_phys;
    logic              cpu_we;
    logic              cpu_re;
    logic [DATA_W-1:0] cpu_rd_word;
    logic [DATA_W-1:0] out_mask;

    nes_palette_init_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_init_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_req     (init_req),
        .run          (run),
        .init_we      (init_we),
        .init_addr    (init_addr),
        .init_data    (init_data),
        .cpu_wr_ready (wr_ready)
    );

    assign cpu.cpu_wr_ready = wr_ready;

    assign init_phys = ADDR_W'(mirror_addr(16'(init_addr), ADDR_W));
    assign ren_phys  = ADDR_W'(mirror_addr(16'(ren_addr), ADDR_W));
    assign cpu_phys  = ADDR_W'(mirror_addr(16'(cpu.cpu_addr), ADDR_W));

    assign cpu_we = cpu.cpu_wr_valid && wr_ready;
    assign cpu_re = cpu.cpu_rd_en && run;

    // CPU read and write share cpu_addr, so a concurrent write is forwarded.
    assign cpu_rd_word = cpu_we ? cpu.cpu_wdata : mem[cpu_phys];

`ifdef NES_PALETTE_GRAY_EN
    assign out_mask = gray ? GRAY_BITS : '1;
`else
    assign out_mask = '1;
`endif

    // init_we and cpu_we are never both set: wr_ready is low throughout INIT.
    always_ff @(posedge clk) begin
        if (init_we)
            mem[init_phys] <= init_data;
        else if (cpu_we)
            mem[cpu_phys] <= cpu.cpu_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ren_data       <= '0;
            cpu.cpu_rdata  <= '0;
            cpu.cpu_rvalid <= 1'b0;
        end else begin
            ren_data       <= run ? (mem[ren_phys] & out_mask) : '0;
            cpu.cpu_rvalid <= cpu_re;
            if (cpu_re)
                cpu.cpu_rdata <= cpu_rd_word & out_mask;
        end
    end

endmodule

// File: tb/tb_nes_palette_ram.sv
// Self-checking bench for nes_palette_ram: directed tables, init/reset sequences, randomized model check.
module tb_nes_palette_ram;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init_req = 1'b0;
    logic [ADDR_W-1:0] ren_addr = '0;
    logic [DATA_W-1:0] ren_data;
`ifdef NES_PALETTE_GRAY_EN
    logic              gray = 1'b0;
`endif

    nes_palette_ram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    nes_palette_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_req (init_req),
        .ren_addr (ren_addr),
        .ren_data (ren_data),
`ifdef NES_PALETTE_GRAY_EN
        .gray     (gray),
`endif
        .cpu      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] pal [32] = '{
        8'h15, 8'h2D, 8'h27, 8'h30, 8'h15, 8'h30, 8'h1A, 8'h09,
        8'h15, 8'h2D, 8'h27, 8'h30, 8'h15, 8'h27, 8'h17, 8'h0F,
        8'h15, 8'h1C, 8'h15, 8'h14, 8'h15, 8'h21, 8'h15, 8'h30,
        8'h15, 8'h1C, 8'h15, 8'h14, 8'h15, 8'h02, 8'h38, 8'h3C
    };

    // Reference contents indexed by physical (post-mirror) entry.
    logic [5:0] model [32];

    typedef struct {
        logic [4:0] addr;
        logic [5:0] expv;
    } vec_t;
    vec_t vecs [10];

    function automatic int phys(input int a);
        if (a >= 16 && (a % 4) == 0)
            return a - 16;
        return a;
    endfunction

    task automatic model_init();
        for (int a = 0; a < 32; a++)
            model[phys(a)] = pal[a][5:0];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        init_req         = 1'b0;
        bus.cpu_addr     = '0;
        bus.cpu_wr_valid = 1'b0;
        bus.cpu_wdata    = '0;
        bus.cpu_rd_en    = 1'b0;
    endtask

    // Counts edges after rst_n release / init_req; checks ready low until edge 32.
    task automatic expect_init_window(input string tag);
        for (int i = 1; i <= 32; i++) begin
            ren_addr      = 5'h1F;
            bus.cpu_rd_en = 1'b1;
            bus.cpu_addr  = 5'h02;
            tick();
            if (i == 10) begin
                check({tag, "_ren_during_init"}, 32'(ren_data), 32'h0);
                check({tag, "_rvalid_during_init"}, 32'(bus.cpu_rvalid), 32'h0);
            end
            if (i == 31)
                check({tag, "_ready_edge31"}, 32'(bus.cpu_wr_ready), 32'h0);
            if (i == 32)
                check({tag, "_ready_edge32"}, 32'(bus.cpu_wr_ready), 32'h1);
        end
        bus.cpu_rd_en = 1'b0;
        model_init();
    endtask

    task automatic cpu_read(input logic [4:0] a, input logic [5:0] expv, input string name);
        bus.cpu_addr  = a;
        bus.cpu_rd_en = 1'b1;
        tick();
        check({name, "_data"}, 32'(bus.cpu_rdata), 32'(expv));
        check({name, "_rvalid"}, 32'(bus.cpu_rvalid), 32'h1);
        bus.cpu_rd_en = 1'b0;
    endtask

    task automatic cpu_write(input logic [4:0] a, input logic [5:0] d);
        bus.cpu_addr     = a;
        bus.cpu_wdata    = d;
        bus.cpu_wr_valid = 1'b1;
        tick();
        bus.cpu_wr_valid = 1'b0;
        model[phys(int'(a))] = d;
    endtask

    initial begin
        vecs[0] = '{5'h1D, 6'h02};
        vecs[1] = '{5'h1F, 6'h3C};
        vecs[2] = '{5'h00, 6'h15};
        vecs[3] = '{5'h10, 6'h15};
        vecs[4] = '{5'h03, 6'h30};
        vecs[5] = '{5'h07, 6'h09};
        vecs[6] = '{5'h0E, 6'h17};
        vecs[7] = '{5'h1E, 6'h38};
        vecs[8] = '{5'h15, 6'h21};
        vecs[9] = '{5'h11, 6'h1C};

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_ren_data", 32'(ren_data), 32'h0);
        check("reset_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        check("reset_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
        check("reset_wr_ready", 32'(bus.cpu_wr_ready), 32'h0);

        rst_n = 1'b1;
        expect_init_window("por");

        foreach (vecs[k]) begin
            ren_addr      = vecs[k].addr;
            bus.cpu_addr  = vecs[k].addr;
            bus.cpu_rd_en = 1'b1;
            tick();
            check($sformatf("tbl_ren_%0h", vecs[k].addr), 32'(ren_data), 32'(vecs[k].expv));
            check($sformatf("tbl_cpu_%0h", vecs[k].addr), 32'(bus.cpu_rdata), 32'(vecs[k].expv));
            check($sformatf("tbl_rvalid_%0h", vecs[k].addr), 32'(bus.cpu_rvalid), 32'h1);
        end
        bus.cpu_rd_en = 1'b0;
        tick();
        check("rvalid_pulse_drop", 32'(bus.cpu_rvalid), 32'h0);

`ifdef NES_PALETTE_GRAY_EN
        gray     = 1'b1;
        ren_addr = 5'h02;
        cpu_read(5'h02, 6'h20, "gray_on_cpu");
        check("gray_on_ren", 32'(ren_data), 32'h20);
        gray = 1'b0;
        cpu_read(5'h02, 6'h27, "gray_off_cpu");
        check("gray_off_ren", 32'(ren_data), 32'h27);
`endif

        cpu_write(5'h10, 6'h2A);
        ren_addr = 5'h10;
        cpu_read(5'h00, 6'h2A, "mirror_wr10_rd00");
        check("mirror_ren10", 32'(ren_data), 32'h2A);

        // Renderer sees old data when the CPU writes the same entry that cycle.
        ren_addr = 5'h07;
        cpu_write(5'h07, 6'h3F);
        check("rbw_old", 32'(ren_data), 32'h09);
        tick();
        check("rbw_new", 32'(ren_data), 32'h3F);

        // Same-cycle CPU write and read: read returns the written value.
        bus.cpu_addr     = 5'h14;
        bus.cpu_wdata    = 6'h0B;
        bus.cpu_wr_valid = 1'b1;
        bus.cpu_rd_en    = 1'b1;
        tick();
        bus.cpu_wr_valid = 1'b0;
        bus.cpu_rd_en    = 1'b0;
        model[phys(5'h14)] = 6'h0B;
        check("wt_data", 32'(bus.cpu_rdata), 32'h0B);
        cpu_read(5'h04, 6'h0B, "wt_mirror04");

        // Write accepted alongside init_req, then overwritten by the reload.
        bus.cpu_addr     = 5'h03;
        bus.cpu_wdata    = 6'h11;
        bus.cpu_wr_valid = 1'b1;
        init_req         = 1'b1;
        tick();
        bus.cpu_wr_valid = 1'b0;
        init_req         = 1'b0;
        check("initreq_ready_low", 32'(bus.cpu_wr_ready), 32'h0);
        expect_init_window("reinit");
        cpu_read(5'h03, 6'h30, "reinit_entry03");

        // Reset pulsed ten cycles into the load restarts it from entry 0.
        cpu_write(5'h05, 6'h01);
        cpu_read(5'h05, 6'h01, "pre_reset_entry05");
        rst_n = 1'b0;
        #1;
        check("async_reset_ready", 32'(bus.cpu_wr_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("midinit_reset_ready", 32'(bus.cpu_wr_ready), 32'h0);
        check("midinit_reset_ren", 32'(ren_data), 32'h0);
        tick();
        rst_n = 1'b1;
        expect_init_window("rst10");
        cpu_read(5'h05, 6'h30, "rst10_entry05");

        // Randomized traffic against the array model.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] ra, ca;
            logic [5:0] wd, exp_ren, exp_cpu, m;
            logic       wr, rd, g;
            ra = 5'($urandom_range(0, 31));
            ca = 5'($urandom_range(0, 31));
            wd = 6'($urandom_range(0, 63));
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            g  = 1'b0;
`ifdef NES_PALETTE_GRAY_EN
            g    = 1'($urandom_range(0, 3) == 0);
            gray = g;
`endif
            m       = g ? 6'h30 : 6'h3F;
            exp_ren = model[phys(int'(ra))] & m;
            exp_cpu = (wr ? wd : model[phys(int'(ca))]) & m;
            ren_addr         = ra;
            bus.cpu_addr     = ca;
            bus.cpu_wdata    = wd;
            bus.cpu_wr_valid = wr;
            bus.cpu_rd_en    = rd;
            tick();
            if (wr)
                model[phys(int'(ca))] = wd;
            check($sformatf("rnd%0d_ren", n), 32'(ren_data), 32'(exp_ren));
            check($sformatf("rnd%0d_rvalid", n), 32'(bus.cpu_rvalid), 32'(rd));
            check($sformatf("rnd%0d_ready", n), 32'(bus.cpu_wr_ready), 32'h1);
            if (rd)
                check($sformatf("rnd%0d_cpu", n), 32'(bus.cpu_rdata), 32'(exp_cpu));
        end
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
